// File: rtl/wb_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_bus_arbiter_pkg
//  Description : Shared constants, arbiter state type and a one-hot to index
//                helper for the Wishbone bus arbiter.
//  Optional    : WB_ARB_TIMEOUT_EN (consumed by wb_bus_arbiter)
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_bus_arbiter_pkg;

  localparam int WB_ARB_MAX_CTL = 8;

  // Controller index assignment on the shared bus
  localparam int WB_CTL_VIDEO = 0;
  localparam int WB_CTL_SPI   = 1;
  localparam int WB_CTL_CPU   = 2;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Index of the highest set bit; callers pass a one-hot (or zero) vector.
  function automatic int onehot_to_idx(input logic [WB_ARB_MAX_CTL-1:0] oh);
    int idx;
    idx = 0;
    for (int k = 0; k < WB_ARB_MAX_CTL; k++) begin
      if (oh[k]) idx = k;
    end
    return idx;
  endfunction

endpackage : wb_bus_arbiter_pkg
`default_nettype wire

// File: rtl/wb_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : wb_rr_picker
//  Description : Combinational round-robin picker. Scans the request vector
//                starting one past the last granted index, wrapping modulo
//                NUM_CTL, and returns the first requester as a one-hot vector.
//  Ports       : req    - request vector (one bit per controller)
//                last   - index of the previously granted controller
//                winner - one-hot winner, all zero when nobody requests
//                valid  - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_rr_picker #(
  parameter int NUM_CTL = 3,
  parameter int IDX_W   = $clog2(NUM_CTL)
) (
  input  logic [NUM_CTL-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_CTL-1:0] winner,
  output logic               valid
);

  logic [IDX_W-1:0] pos;

  // The scan ends at offset NUM_CTL, so the last-granted controller itself
  // has the lowest priority on the following arbitration.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    pos    = '0;
    for (int off = 1; off <= NUM_CTL; off++) begin
      pos = IDX_W'((int'(last) + off) % NUM_CTL);
      if (!valid && req[pos]) begin
        winner[pos] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule : wb_rr_picker
`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_bus_arbiter
//  Description : Round-robin arbiter sharing one pipelined Wishbone B4 bus
//                between NUM_CTL controllers (0 = video fetch). One grant per
//                bus cycle, one dead clock between grants.
//  Optional    : define WB_ARB_TIMEOUT_EN to enable the ack timeout abort
//                (TIMEOUT clocks of wb_cycle_o without ack).
//  Ports       : wb_clock_i, reset_i (async, active high)
//                ctl_*_i / ctl_*_o - controller-side CYC/STB/WE/ADR/DAT,
//                                    STALL/ACK per controller, read data
//                                    broadcast
//                wb_*_o / wb_*_i   - downstream bus
//                grant_o           - one-hot current grant
//                timeout_o         - sticky abort flag
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int NUM_CTL       = 3,
  parameter int TIMEOUT       = 255,
  parameter int WB_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                             wb_clock_i,
  input  logic                             reset_i,
  input  logic [NUM_CTL-1:0]               ctl_cycle_i,
  input  logic [NUM_CTL-1:0]               ctl_strobe_i,
  input  logic [NUM_CTL-1:0]               ctl_we_i,
  input  logic [NUM_CTL*WB_ADDR_WIDTH-1:0] ctl_addr_i,
  input  logic [NUM_CTL*DATA_WIDTH-1:0]    ctl_data_i,
  output logic [DATA_WIDTH-1:0]            ctl_data_o,
  output logic [NUM_CTL-1:0]               ctl_stall_o,
  output logic [NUM_CTL-1:0]               ctl_ack_o,
  output logic [WB_ADDR_WIDTH-1:0]         wb_addr_o,
  output logic [DATA_WIDTH-1:0]            wb_data_o,
  output logic                             wb_we_o,
  output logic                             wb_cycle_o,
  output logic                             wb_strobe_o,
  input  logic                             wb_stall_i,
  input  logic                             wb_ack_i,
  input  logic [DATA_WIDTH-1:0]            wb_data_i,
  output logic [NUM_CTL-1:0]               grant_o,
  output logic                             timeout_o
);

  localparam int IDX_W = $clog2(NUM_CTL);

  arb_state_t         state;
  logic [IDX_W-1:0]   last;
  logic [NUM_CTL-1:0] pick_oh;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   sel;
  logic               granted;
  logic               sel_cyc;
  logic               bus_live;
  logic               to_hit;

  wb_rr_picker #(
    .NUM_CTL (NUM_CTL),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (ctl_cycle_i),
    .last   (last),
    .winner (pick_oh),
    .valid  (pick_valid)
  );

  assign pick_idx = IDX_W'(onehot_to_idx(WB_ARB_MAX_CTL'(pick_oh)));

  // While idle the mux points at controller 0; STB is low so it is harmless.
  assign granted = (state == ARB_GRANT);
  assign sel     = granted ? last : '0;
  assign sel_cyc = ctl_cycle_i[sel];

  // --------------------------------------------------------------------------
  // Arbitration FSM. The grant register is asynchronously reset, so all bus
  // outputs derived from it collapse as soon as reset_i rises.
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clock_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= ARB_IDLE;
      last    <= IDX_W'(NUM_CTL - 1);
      grant_o <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state   <= ARB_GRANT;
            last    <= pick_idx;
            grant_o <= pick_oh;
          end
        end
        ARB_GRANT: begin
          // Release as soon as the owner drops CYC, even with a strobe
          // still unacked; any late ack is then not routed to anybody.
          if (!sel_cyc) begin
            state   <= ARB_IDLE;
            grant_o <= '0;
          end
        end
        default: begin
          state   <= ARB_IDLE;
          grant_o <= '0;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] to_cnt;
  logic             aborted;
  logic             to_flag;

  // Once the abort fires the bus stays released until the owner drops CYC.
  assign bus_live  = granted && !aborted;
  assign to_hit    = bus_live && (to_cnt == CNT_W'(TIMEOUT));
  assign timeout_o = to_flag;

  always_ff @(posedge wb_clock_i or posedge reset_i) begin
    if (reset_i) begin
      to_cnt  <= '0;
      aborted <= 1'b0;
      to_flag <= 1'b0;
    end else begin
      if (!granted || (wb_ack_i && wb_cycle_o)) begin
        to_cnt <= '0;
      end else if (wb_cycle_o) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (!granted) begin
        aborted <= 1'b0;
      end else if (to_hit) begin
        aborted <= 1'b1;
      end

      if (to_hit) begin
        to_flag <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign bus_live  = granted;
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Downstream muxing from the registered grant
  // --------------------------------------------------------------------------
  assign wb_cycle_o  = bus_live && sel_cyc && !to_hit;
  assign wb_strobe_o = wb_cycle_o && ctl_strobe_i[sel];
  assign wb_we_o     = wb_cycle_o && ctl_we_i[sel];
  assign wb_addr_o   = ctl_addr_i[sel*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
  assign wb_data_o   = ctl_data_i[sel*DATA_WIDTH +: DATA_WIDTH];

  // An aborted cycle returns all-ones data alongside its forced ack.
  assign ctl_data_o  = to_hit ? {DATA_WIDTH{1'b1}} : wb_data_i;

  // --------------------------------------------------------------------------
  // Upstream stall/ack routing: only the owner sees the bus, everyone else
  // is stalled.
  // --------------------------------------------------------------------------
  always_comb begin
    ctl_stall_o = '1;
    ctl_ack_o   = '0;
    if (granted) begin
      ctl_stall_o[sel] = bus_live ? wb_stall_i : 1'b1;
      ctl_ack_o[sel]   = to_hit || (bus_live && sel_cyc && wb_ack_i);
    end
  end

endmodule : wb_bus_arbiter
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_bus_arbiter
//  Description : Self-checking bench for wb_bus_arbiter (NUM_CTL=3, 16-bit
//                address, 8-bit data). Directed vector table plus hand-written
//                multi-cycle sequences. The WB_ARB_TIMEOUT_EN sequence runs
//                only when that macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bus_arbiter;

  logic        clk;
  logic        reset_i;
  logic [2:0]  ctl_cycle_i, ctl_strobe_i, ctl_we_i;
  logic [47:0] ctl_addr_i;
  logic [23:0] ctl_data_i;
  logic [7:0]  ctl_data_o;
  logic [2:0]  ctl_stall_o, ctl_ack_o;
  logic [15:0] wb_addr_o;
  logic [7:0]  wb_data_o;
  logic        wb_we_o, wb_cycle_o, wb_strobe_o;
  logic        wb_stall_i, wb_ack_i;
  logic [7:0]  wb_data_i;
  logic [2:0]  grant_o;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  wb_bus_arbiter #(
    .NUM_CTL       (3),
    .TIMEOUT       (4),
    .WB_ADDR_WIDTH (16),
    .DATA_WIDTH    (8)
  ) dut (
    .wb_clock_i   (clk),
    .reset_i      (reset_i),
    .ctl_cycle_i  (ctl_cycle_i),
    .ctl_strobe_i (ctl_strobe_i),
    .ctl_we_i     (ctl_we_i),
    .ctl_addr_i   (ctl_addr_i),
    .ctl_data_i   (ctl_data_i),
    .ctl_data_o   (ctl_data_o),
    .ctl_stall_o  (ctl_stall_o),
    .ctl_ack_o    (ctl_ack_o),
    .wb_addr_o    (wb_addr_o),
    .wb_data_o    (wb_data_o),
    .wb_we_o      (wb_we_o),
    .wb_cycle_o   (wb_cycle_o),
    .wb_strobe_o  (wb_strobe_o),
    .wb_stall_i   (wb_stall_i),
    .wb_ack_i     (wb_ack_i),
    .wb_data_i    (wb_data_i),
    .grant_o      (grant_o),
    .timeout_o    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  cyc, stb, we;
    logic        wstall, wack;
    logic [7:0]  wdata;
    logic [2:0]  e_grant, e_stall, e_ack;
    logic        e_wcyc, e_wstb, e_wwe;
    logic [15:0] e_waddr;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic rst, input logic [2:0] cyc, stb, we,
                              input logic ws, wa, input logic [7:0] wd,
                              input logic [2:0] eg, es, ea,
                              input logic ec, est, ewe, input logic [15:0] ead);
    vec_t t;
    t.rst = rst; t.cyc = cyc; t.stb = stb; t.we = we;
    t.wstall = ws; t.wack = wa; t.wdata = wd;
    t.e_grant = eg; t.e_stall = es; t.e_ack = ea;
    t.e_wcyc = ec; t.e_wstb = est; t.e_wwe = ewe; t.e_waddr = ead;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: step to the falling edge, then sample shortly after it.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_grant(input string name, input logic [2:0] exp);
    for (int i = 0; i < 4 && grant_o !== exp; i++) tick();
    check(name, 64'(grant_o), 64'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1; ctl_cycle_i = '0; ctl_strobe_i = '0; ctl_we_i = '0;
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_data_i = '0;
    @(negedge clk);
    reset_i = 1'b0;
    #2;
  endtask

  initial begin
    reset_i = 1'b1; ctl_cycle_i = '0; ctl_strobe_i = '0; ctl_we_i = '0;
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_data_i = '0;
    ctl_addr_i = {16'h2000, 16'h8000, 16'h1000};
    ctl_data_i = {8'hC2, 8'hC1, 8'hC0};

    //              rst cyc     stb     we      ws   wa   wd     grant   stall   ack     wc   wst  wwe  addr
    // Single requester ctl1, ack two clocks after the grant
    tbl[0]  = mk(1, 3'b000, 3'b000, 3'b000, 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, 0, 16'h1000);
    tbl[1]  = mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, 0, 16'h1000);
    tbl[2]  = mk(0, 3'b010, 3'b010, 3'b010, 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, 0, 16'h1000);
    tbl[3]  = mk(0, 3'b010, 3'b010, 3'b010, 0, 0, 8'h00, 3'b010, 3'b101, 3'b000, 1, 1, 1, 16'h8000);
    tbl[4]  = mk(0, 3'b010, 3'b000, 3'b010, 0, 0, 8'h00, 3'b010, 3'b101, 3'b000, 1, 0, 1, 16'h8000);
    tbl[5]  = mk(0, 3'b010, 3'b000, 3'b010, 0, 1, 8'h5A, 3'b010, 3'b101, 3'b010, 1, 0, 1, 16'h8000);
    tbl[6]  = mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 8'h00, 3'b010, 3'b101, 3'b000, 0, 0, 0, 16'h8000);
    tbl[7]  = mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, 0, 16'h1000);
    // All request from reset: order 0,1,2,0 with one idle clock between
    tbl[8]  = mk(1, 3'b000, 3'b000, 3'b000, 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, 0, 16'h1000);
    tbl[9]  = mk(0, 3'b111, 3'b111, 3'b000, 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, 0, 16'h1000);
    tbl[10] = mk(0, 3'b111, 3'b111, 3'b000, 0, 1, 8'h11, 3'b001, 3'b110, 3'b001, 1, 1, 0, 16'h1000);
    tbl[11] = mk(0, 3'b110, 3'b110, 3'b000, 0, 1, 8'h00, 3'b001, 3'b110, 3'b000, 0, 0, 0, 16'h1000);
    tbl[12] = mk(0, 3'b110, 3'b110, 3'b000, 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, 0, 16'h1000);
    tbl[13] = mk(0, 3'b110, 3'b110, 3'b000, 0, 1, 8'h22, 3'b010, 3'b101, 3'b010, 1, 1, 0, 16'h8000);
    tbl[14] = mk(0, 3'b101, 3'b101, 3'b000, 0, 0, 8'h00, 3'b010, 3'b101, 3'b000, 0, 0, 0, 16'h8000);
    tbl[15] = mk(0, 3'b101, 3'b101, 3'b000, 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, 0, 16'h1000);
    tbl[16] = mk(0, 3'b101, 3'b101, 3'b000, 0, 1, 8'h33, 3'b100, 3'b011, 3'b100, 1, 1, 0, 16'h2000);
    tbl[17] = mk(0, 3'b001, 3'b001, 3'b000, 0, 0, 8'h00, 3'b100, 3'b011, 3'b000, 0, 0, 0, 16'h2000);
    tbl[18] = mk(0, 3'b001, 3'b001, 3'b000, 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, 0, 16'h1000);
    tbl[19] = mk(0, 3'b001, 3'b001, 3'b000, 0, 0, 8'h00, 3'b001, 3'b110, 3'b000, 1, 1, 0, 16'h1000);
    tbl[20] = mk(0, 3'b000, 3'b000, 3'b000, 0, 1, 8'h00, 3'b001, 3'b110, 3'b000, 0, 0, 0, 16'h1000);
    tbl[21] = mk(0, 3'b000, 3'b000, 3'b000, 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, 0, 16'h1000);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset_i = tbl[i].rst; ctl_cycle_i = tbl[i].cyc; ctl_strobe_i = tbl[i].stb;
      ctl_we_i = tbl[i].we; wb_stall_i = tbl[i].wstall; wb_ack_i = tbl[i].wack;
      wb_data_i = tbl[i].wdata;
      #2;
      check($sformatf("vec%0d", i),
            64'({grant_o, ctl_stall_o, ctl_ack_o, wb_cycle_o, wb_strobe_o, wb_we_o,
                 wb_addr_o, ctl_data_o, timeout_o}),
            64'({tbl[i].e_grant, tbl[i].e_stall, tbl[i].e_ack, tbl[i].e_wcyc,
                 tbl[i].e_wstb, tbl[i].e_wwe, tbl[i].e_waddr, tbl[i].wdata, 1'b0}));
    end

    // Downstream stall held for three granted clocks
    do_reset();
    ctl_cycle_i = 3'b001; ctl_strobe_i = 3'b001; wb_stall_i = 1'b1;
    wait_grant("stall_grant", 3'b001);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_hold%0d", i), 64'(ctl_stall_o), 64'(3'b111));
      check($sformatf("stall_addr%0d", i), 64'(wb_addr_o), 64'(16'h1000));
      check($sformatf("stall_stb%0d", i), 64'(wb_strobe_o), 64'(1'b1));
      if (i < 2) tick();
    end
    wb_stall_i = 1'b0;
    tick();
    check("stall_release", 64'(ctl_stall_o), 64'(3'b110));
    ctl_cycle_i = '0; ctl_strobe_i = '0;
    tick();
    tick();

    // ctl2 pulses CYC for one clock while ctl0 holds the bus
    ctl_cycle_i = 3'b001; ctl_strobe_i = 3'b001;
    wait_grant("skip_grant0", 3'b001);
    ctl_cycle_i = 3'b101;
    tick();
    check("skip_hold", 64'(grant_o), 64'(3'b001));
    ctl_cycle_i = 3'b001;
    tick();
    ctl_cycle_i = 3'b000; ctl_strobe_i = 3'b000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("skip_never2_%0d", i), 64'(grant_o == 3'b100), 64'(1'b0));
    end
    check("skip_idle", 64'(grant_o), 64'(3'b000));

    // Asynchronous reset in the middle of a granted cycle
    ctl_cycle_i = 3'b010; ctl_strobe_i = 3'b010;
    wait_grant("rst_grant1", 3'b010);
    check("rst_cyc_before", 64'(wb_cycle_o), 64'(1'b1));
    #1 reset_i = 1'b1;
    #1;
    check("rst_async_cyc", 64'(wb_cycle_o), 64'(1'b0));
    check("rst_async_stb", 64'(wb_strobe_o), 64'(1'b0));
    check("rst_async_grant", 64'(grant_o), 64'(3'b000));
    @(negedge clk);
    reset_i = 1'b0; ctl_cycle_i = 3'b111; ctl_strobe_i = 3'b111;
    #2;
    check("rst_after_idle", 64'(grant_o), 64'(3'b000));
    tick();
    check("rst_first_ctl0", 64'(grant_o), 64'(3'b001));
    ctl_cycle_i = '0; ctl_strobe_i = '0;
    tick();
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    // No ack ever arrives: abort after TIMEOUT=4 clocks of wb_cycle_o
    do_reset();
    wb_data_i = 8'h00;
    ctl_cycle_i = 3'b001; ctl_strobe_i = 3'b001;
    wait_grant("to_grant", 3'b001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("to_wait%0d", i), 64'({ctl_ack_o, wb_cycle_o, timeout_o}),
            64'({3'b000, 1'b1, 1'b0}));
    end
    tick();
    check("to_ack", 64'(ctl_ack_o), 64'(3'b001));
    check("to_data", 64'(ctl_data_o), 64'(8'hFF));
    check("to_cyc", 64'(wb_cycle_o), 64'(1'b0));
    tick();
    check("to_flag", 64'({timeout_o, ctl_ack_o, wb_cycle_o, grant_o}),
          64'({1'b1, 3'b000, 1'b0, 3'b001}));
    ctl_cycle_i = '0; ctl_strobe_i = '0;
    tick();
    tick();
    check("to_sticky", 64'({timeout_o, grant_o}), 64'({1'b1, 3'b000}));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_bus_arbiter
`default_nettype wire
